// File: rtl/shape_seq_ctrl_if.sv
// rtl/shape_seq_ctrl_if.sv - command, FIFO and generator handshake bundle for shape_seq_ctrl
interface shape_seq_ctrl_if #(
   parameter int MAX_VERTS = 8,
   parameter int SEL_W     = 4
);
   localparam int VW = $clog2(MAX_VERTS + 1);

   logic             new_shape;
   logic [3:0]       shapeid;
   logic [VW-1:0]    num_verts;
   logic             waitrequest;
   logic             data_ready;
   logic             data_sent;
   logic             line_done;
   logic             arc_done;
   logic             prim_sel;
   logic             write;
   logic             read;
   logic             enable;
   logic [SEL_W-1:0] output_sel;
   logic             shape_done;
   logic             shape_err;
   logic             busy;

   modport master (
      input  new_shape, shapeid, num_verts, waitrequest,
             data_ready, data_sent, line_done, arc_done,
      output prim_sel, write, read, enable, output_sel,
             shape_done, shape_err, busy
   );

   modport slave (
      output new_shape, shapeid, num_verts, waitrequest,
             data_ready, data_sent, line_done, arc_done,
      input  prim_sel, write, read, enable, output_sel,
             shape_done, shape_err, busy
   );
endinterface

// File: rtl/shape_seq_ctrl.sv
// rtl/shape_seq_ctrl.sv - 2D shape draw sequencer; SHAPE_SEQ_PIXCNT_EN adds the pix_count output
module shape_seq_ctrl #(
   parameter int MAX_VERTS = 8,
   parameter int NUM_ARCS  = 8,
   parameter int SEL_W     = 4
) (
   input  logic             clk,
   input  logic             nreset,
   shape_seq_ctrl_if.master bus
`ifdef SHAPE_SEQ_PIXCNT_EN
   ,
   output logic [15:0]      pix_count
`endif
);
   localparam int VW = $clog2(MAX_VERTS + 1);
   localparam logic [3:0]       SH_LINE   = 4'd0;
   localparam logic [3:0]       SH_TRI    = 4'd1;
   localparam logic [3:0]       SH_POLY   = 4'd2;
   localparam logic [3:0]       SH_CIRCLE = 4'd3;
   localparam logic [VW-1:0]    ONE_V     = VW'(1);
   localparam logic [SEL_W-1:0] LAST_ARC  = SEL_W'(NUM_ARCS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_IDENT, S_SEND, S_MAKE, S_OUTPIX, S_CLEAR, S_DONE, S_ERR
   } state_t;

   state_t           state, state_nx;
   logic [3:0]       shape_q, shape_nx;
   logic [VW-1:0]    nverts_q, nverts_nx;
   logic [VW-1:0]    nprim_q, nprim_nx;
   logic [VW-1:0]    k_q, k_nx;
   logic [SEL_W-1:0] a_q, a_nx;
   logic             is_circ;
   logic             last_k;
   logic [SEL_W-1:0] draw_sel;

   assign is_circ  = (shape_q == SH_CIRCLE);
   assign last_k   = (k_q == nprim_q - ONE_V);
   // The arc engine is addressed by arc index, the line engine by primitive index
   assign draw_sel = is_circ ? a_q : SEL_W'(k_q);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= S_IDLE;
         shape_q  <= '0;
         nverts_q <= '0;
         nprim_q  <= '0;
         k_q      <= '0;
         a_q      <= '0;
      end else begin
         state    <= state_nx;
         shape_q  <= shape_nx;
         nverts_q <= nverts_nx;
         nprim_q  <= nprim_nx;
         k_q      <= k_nx;
         a_q      <= a_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      shape_nx       = shape_q;
      nverts_nx      = nverts_q;
      nprim_nx       = nprim_q;
      k_nx           = k_q;
      a_nx           = a_q;
      bus.prim_sel   = 1'b0;
      bus.write      = 1'b0;
      bus.read       = 1'b0;
      bus.enable     = 1'b0;
      bus.output_sel = '0;
      bus.shape_done = 1'b0;
      bus.shape_err  = 1'b0;
      bus.busy       = (state != S_IDLE);

      case (state)
         S_IDLE: begin
            if (bus.new_shape) begin
               state_nx  = S_IDENT;
               shape_nx  = bus.shapeid;
               nverts_nx = bus.num_verts;
            end
         end
         S_IDENT: begin
            k_nx     = '0;
            a_nx     = '0;
            state_nx = S_SEND;
            case (shape_q)
               SH_LINE, SH_CIRCLE: nprim_nx = ONE_V;
               SH_TRI:             nprim_nx = VW'(3);
               SH_POLY: begin
                  nprim_nx = nverts_q;
                  if (nverts_q < VW'(3) || nverts_q > VW'(MAX_VERTS))
                     state_nx = S_ERR;
               end
               default: state_nx = S_ERR;
            endcase
         end
         S_SEND: begin
            bus.write      = 1'b1;
            bus.prim_sel   = is_circ;
            bus.output_sel = is_circ ? '0 : SEL_W'(k_q);
            if (!bus.waitrequest) begin
               if (last_k) begin
                  state_nx = S_MAKE;
                  k_nx     = '0;
                  a_nx     = '0;
               end else begin
                  k_nx = k_q + ONE_V;
               end
            end
         end
         S_MAKE: begin
            bus.enable     = 1'b1;
            bus.prim_sel   = is_circ;
            bus.output_sel = draw_sel;
            // Completion wins over a pending pixel; arc_done only counts at arc 0
            if (is_circ ? (bus.arc_done && a_q == '0) : bus.line_done)
               state_nx = S_CLEAR;
            else if (bus.data_ready)
               state_nx = S_OUTPIX;
         end
         S_OUTPIX: begin
            bus.prim_sel   = is_circ;
            bus.output_sel = draw_sel;
            if (bus.data_sent) begin
               state_nx = S_MAKE;
               if (is_circ)
                  a_nx = (a_q == LAST_ARC) ? '0 : a_q + SEL_W'(1);
            end
         end
         S_CLEAR: begin
            bus.read       = 1'b1;
            bus.prim_sel   = is_circ;
            bus.output_sel = draw_sel;
            if (!bus.waitrequest) begin
               if (last_k) begin
                  state_nx = S_DONE;
               end else begin
                  k_nx     = k_q + ONE_V;
                  state_nx = S_MAKE;
               end
            end
         end
         S_DONE: begin
            bus.shape_done = 1'b1;
            state_nx       = S_IDLE;
         end
         S_ERR: begin
            bus.shape_err = 1'b1;
            state_nx      = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef SHAPE_SEQ_PIXCNT_EN
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         pix_count <= '0;
      else if (state == S_IDLE && bus.new_shape)
         pix_count <= '0;
      else if (state == S_OUTPIX && bus.data_sent && pix_count != 16'hFFFF)
         pix_count <= pix_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_shape_seq_ctrl.sv
// tb/tb_shape_seq_ctrl.sv - scoreboard bench for shape_seq_ctrl; honours SHAPE_SEQ_PIXCNT_EN
module tb_shape_seq_ctrl;
   localparam int MAX_VERTS = 8;
   localparam int NUM_ARCS  = 8;
   localparam int SEL_W     = 4;
   localparam logic [1:0] EV_W = 2'd0, EV_R = 2'd1, EV_D = 2'd2, EV_E = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [3:0] sel;
   } ev_t;

   logic clk    = 1'b0;
   logic nreset = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   ev_t  sb[$];

   shape_seq_ctrl_if #(.MAX_VERTS(MAX_VERTS), .SEL_W(SEL_W)) bus ();

`ifdef SHAPE_SEQ_PIXCNT_EN
   logic [15:0] pix_count;
   shape_seq_ctrl #(.MAX_VERTS(MAX_VERTS), .NUM_ARCS(NUM_ARCS), .SEL_W(SEL_W)) dut (
      .clk(clk), .nreset(nreset), .bus(bus), .pix_count(pix_count));
`else
   shape_seq_ctrl #(.MAX_VERTS(MAX_VERTS), .NUM_ARCS(NUM_ARCS), .SEL_W(SEL_W)) dut (
      .clk(clk), .nreset(nreset), .bus(bus));
`endif

   always #5 clk = ~clk;

   // Accepted FIFO accesses and completion pulses are matched against the expected stream
   always @(negedge clk) begin
      ev_t got;
      ev_t exp_ev;
      bit  have;
      have = 1'b0;
      got  = '0;
      if (bus.write && !bus.waitrequest) begin got.kind = EV_W; got.sel = bus.output_sel; have = 1'b1; end
      else if (bus.read && !bus.waitrequest) begin got.kind = EV_R; got.sel = bus.output_sel; have = 1'b1; end
      else if (bus.shape_done) begin got.kind = EV_D; have = 1'b1; end
      else if (bus.shape_err) begin got.kind = EV_E; have = 1'b1; end
      if (have) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: got kind=%0d sel=%0d, required no event", got.kind, got.sel);
         end else begin
            exp_ev = sb.pop_front();
            if (got !== exp_ev) begin
               n_fail++;
               $display("FAIL sb_event: got kind=%0d sel=%0d, required kind=%0d sel=%0d",
                        got.kind, got.sel, exp_ev.kind, exp_ev.sel);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] kind, input logic [3:0] sel);
      ev_t e;
      e.kind = kind;
      e.sel  = sel;
      sb.push_back(e);
   endtask

   task automatic start_shape(input logic [3:0] id, input logic [3:0] nv);
      bus.new_shape = 1'b1;
      bus.shapeid   = id;
      bus.num_verts = nv;
      tick();
      bus.new_shape = 1'b0;
   endtask

   task automatic do_pixel();
      bus.data_ready = 1'b1;
      tick();
      bus.data_ready = 1'b0;
      bus.data_sent  = 1'b1;
      tick();
      bus.data_sent  = 1'b0;
   endtask

   task automatic wait_enable(input string tag);
      int n = 0;
      while (bus.enable !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (bus.enable !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: enable=%b, required 1 within 40 cycles", tag, bus.enable);
      end
   endtask

   task automatic run_triangle(input string tag);
      for (int i = 0; i < 3; i++) push(EV_W, 4'(i));
      for (int i = 0; i < 3; i++) push(EV_R, 4'(i));
      push(EV_D, 4'd0);
      start_shape(4'd1, 4'd0);
      n_checks++;
      if (bus.write !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ident: write=%b busy=%b, required 0 1", tag, bus.write, bus.busy);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.write !== 1'b1 || bus.output_sel !== 4'(i)) begin
            n_fail++;
            $display("FAIL %s_write%0d: write=%b sel=%0d, required 1 %0d", tag, i, bus.write, bus.output_sel, i);
         end
         tick();
      end
      for (int l = 0; l < 3; l++) begin
         n_checks++;
         if (bus.enable !== 1'b1 || bus.output_sel !== 4'(l)) begin
            n_fail++;
            $display("FAIL %s_make%0d: enable=%b sel=%0d, required 1 %0d", tag, l, bus.enable, bus.output_sel, l);
         end
         do_pixel();
         do_pixel();
         bus.line_done = 1'b1;
         tick();
         bus.line_done = 1'b0;
         n_checks++;
         if (bus.read !== 1'b1 || bus.output_sel !== 4'(l)) begin
            n_fail++;
            $display("FAIL %s_read%0d: read=%b sel=%0d, required 1 %0d", tag, l, bus.read, bus.output_sel, l);
         end
         tick();
      end
      n_checks++;
      if (bus.shape_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_done: shape_done=%b, required 1", tag, bus.shape_done);
      end
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.shape_done !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_idle: busy=%b done=%b pending=%0d, required 0 0 0", tag, bus.busy, bus.shape_done, sb.size());
      end
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({bus.prim_sel, bus.write, bus.read, bus.enable, bus.output_sel,
           bus.shape_done, bus.shape_err, bus.busy} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: write=%b read=%b enable=%b sel=%0d busy=%b, required all 0",
                  bus.write, bus.read, bus.enable, bus.output_sel, bus.busy);
      end
      nreset = 1'b1;
      tick();
   endtask

   task automatic test_triangle();
      run_triangle("tri");
   endtask

   task automatic test_polygon_stall();
      int held = 0;
      for (int i = 0; i < 5; i++) push(EV_W, 4'(i));
      for (int i = 0; i < 5; i++) push(EV_R, 4'(i));
      push(EV_D, 4'd0);
      start_shape(4'd2, 4'd5);
      tick();
      tick();
      while (bus.write === 1'b1 && bus.output_sel === 4'd1 && held < 10) begin
         bus.waitrequest = (held < 2);
         held++;
         tick();
      end
      bus.waitrequest = 1'b0;
      n_checks++;
      if (held != 3 || bus.output_sel !== 4'd2) begin
         n_fail++;
         $display("FAIL poly_write_hold: cycles=%0d next_sel=%0d, required 3 2", held, bus.output_sel);
      end
      for (int l = 0; l < 5; l++) begin
         wait_enable("poly_make");
         n_checks++;
         if (bus.output_sel !== 4'(l)) begin
            n_fail++;
            $display("FAIL poly_make%0d: sel=%0d, required %0d", l, bus.output_sel, l);
         end
         do_pixel();
         bus.line_done = 1'b1;
         tick();
         bus.line_done = 1'b0;
         if (l == 3) begin
            bus.waitrequest = 1'b1;
            tick();
            n_checks++;
            if (bus.read !== 1'b1 || bus.output_sel !== 4'd3) begin
               n_fail++;
               $display("FAIL poly_read_hold: read=%b sel=%0d, required 1 3", bus.read, bus.output_sel);
            end
            bus.waitrequest = 1'b0;
         end
         tick();
      end
      n_checks++;
      if (bus.shape_done !== 1'b1) begin
         n_fail++;
         $display("FAIL poly_done: shape_done=%b, required 1", bus.shape_done);
      end
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL poly_idle: busy=%b pending=%0d, required 0 0", bus.busy, sb.size());
      end
   endtask

   task automatic test_circle();
      push(EV_W, 4'd0);
      push(EV_R, 4'd0);
      push(EV_D, 4'd0);
      start_shape(4'd3, 4'd0);
      tick();
      n_checks++;
      if (bus.write !== 1'b1 || bus.prim_sel !== 1'b1 || bus.output_sel !== 4'd0) begin
         n_fail++;
         $display("FAIL circ_write: write=%b prim_sel=%b sel=%0d, required 1 1 0", bus.write, bus.prim_sel, bus.output_sel);
      end
      tick();
      for (int i = 0; i < 16; i++) begin
         if (i == 10) begin
            bus.arc_done = 1'b1;
            tick();
            bus.arc_done = 1'b0;
            n_checks++;
            if (bus.enable !== 1'b1 || bus.read !== 1'b0 || bus.output_sel !== 4'd2) begin
               n_fail++;
               $display("FAIL circ_arc_early: enable=%b read=%b sel=%0d, required 1 0 2", bus.enable, bus.read, bus.output_sel);
            end
         end
         n_checks++;
         if (bus.enable !== 1'b1 || bus.output_sel !== 4'(i % NUM_ARCS)) begin
            n_fail++;
            $display("FAIL circ_arc%0d: enable=%b sel=%0d, required 1 %0d", i, bus.enable, bus.output_sel, i % NUM_ARCS);
         end
         do_pixel();
      end
      bus.arc_done = 1'b1;
      tick();
      bus.arc_done = 1'b0;
      n_checks++;
      if (bus.read !== 1'b1 || bus.prim_sel !== 1'b1 || bus.output_sel !== 4'd0) begin
         n_fail++;
         $display("FAIL circ_clear: read=%b prim_sel=%b sel=%0d, required 1 1 0", bus.read, bus.prim_sel, bus.output_sel);
      end
      tick();
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL circ_idle: busy=%b pending=%0d, required 0 0", bus.busy, sb.size());
      end
   endtask

   task automatic test_errors();
      logic [3:0] ids [3];
      logic [3:0] nvs [3];
      ids = '{4'd7, 4'd2, 4'd2};
      nvs = '{4'd0, 4'd2, 4'd9};
      for (int c = 0; c < 3; c++) begin
         push(EV_E, 4'd0);
         start_shape(ids[c], nvs[c]);
         tick();
         n_checks++;
         if (bus.shape_err !== 1'b1 || bus.write !== 1'b0 || bus.read !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err%0d_pulse: err=%b write=%b read=%b busy=%b, required 1 0 0 1",
                     c, bus.shape_err, bus.write, bus.read, bus.busy);
         end
         tick();
         n_checks++;
         if (bus.busy !== 1'b0 || bus.shape_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err%0d_idle: busy=%b err=%b, required 0 0", c, bus.busy, bus.shape_err);
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL err_pending: pending=%0d, required 0", sb.size());
      end
   endtask

   task automatic test_line_pixels();
      for (int s = 0; s < 2; s++) begin
         push(EV_W, 4'd0);
         push(EV_R, 4'd0);
         push(EV_D, 4'd0);
         start_shape(4'd0, 4'd0);
`ifdef SHAPE_SEQ_PIXCNT_EN
         n_checks++;
         if (pix_count !== 16'd0) begin
            n_fail++;
            $display("FAIL line%0d_pix_clear: pix_count=%0d, required 0", s, pix_count);
         end
`endif
         tick();
         tick();
         // A new command while drawing must be ignored
         bus.new_shape = 1'b1;
         bus.shapeid   = 4'd7;
         tick();
         bus.new_shape = 1'b0;
         n_checks++;
         if (bus.enable !== 1'b1 || bus.prim_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL line%0d_ignore: enable=%b prim_sel=%b, required 1 0", s, bus.enable, bus.prim_sel);
         end
         for (int p = 0; p < 37; p++) do_pixel();
         bus.line_done = 1'b1;
         bus.data_ready = 1'b1;
         tick();
         bus.line_done = 1'b0;
         bus.data_ready = 1'b0;
         n_checks++;
         if (bus.read !== 1'b1) begin
            n_fail++;
            $display("FAIL line%0d_clear: read=%b, required 1", s, bus.read);
         end
         tick();
         n_checks++;
         if (bus.shape_done !== 1'b1) begin
            n_fail++;
            $display("FAIL line%0d_done: shape_done=%b, required 1", s, bus.shape_done);
         end
`ifdef SHAPE_SEQ_PIXCNT_EN
         n_checks++;
         if (pix_count !== 16'd37) begin
            n_fail++;
            $display("FAIL line%0d_pix_count: pix_count=%0d, required 37", s, pix_count);
         end
`endif
         tick();
`ifdef SHAPE_SEQ_PIXCNT_EN
         n_checks++;
         if (pix_count !== 16'd37) begin
            n_fail++;
            $display("FAIL line%0d_pix_hold: pix_count=%0d, required 37", s, pix_count);
         end
`endif
      end
      n_checks++;
      if (bus.busy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL line_idle: busy=%b pending=%0d, required 0 0", bus.busy, sb.size());
      end
   endtask

   task automatic test_reset_mid_shape();
      for (int i = 0; i < 3; i++) push(EV_W, 4'(i));
      push(EV_R, 4'd0);
      start_shape(4'd1, 4'd0);
      for (int i = 0; i < 4; i++) tick();
      do_pixel();
      bus.line_done = 1'b1;
      tick();
      bus.line_done = 1'b0;
      tick();
      bus.data_ready = 1'b1;
      tick();
      bus.data_ready = 1'b0;
      n_checks++;
      if (bus.enable !== 1'b0 || bus.busy !== 1'b1 || bus.output_sel !== 4'd1) begin
         n_fail++;
         $display("FAIL rst_outpix: enable=%b busy=%b sel=%0d, required 0 1 1", bus.enable, bus.busy, bus.output_sel);
      end
      nreset = 1'b0;
      #1;
      n_checks++;
      if ({bus.prim_sel, bus.write, bus.read, bus.enable, bus.output_sel,
           bus.shape_done, bus.shape_err, bus.busy} !== 11'd0) begin
         n_fail++;
         $display("FAIL rst_async: write=%b read=%b enable=%b sel=%0d busy=%b, required all 0",
                  bus.write, bus.read, bus.enable, bus.output_sel, bus.busy);
      end
      bus.data_sent = 1'b1;
      tick();
      tick();
      bus.data_sent = 1'b0;
      nreset = 1'b1;
      tick();
      n_checks++;
      if (sb.size() != 0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_pending: pending=%0d busy=%b, required 0 0", sb.size(), bus.busy);
      end
      run_triangle("after_rst");
   endtask

   initial begin
      bus.new_shape   = 1'b0;
      bus.shapeid     = 4'd0;
      bus.num_verts   = '0;
      bus.waitrequest = 1'b0;
      bus.data_ready  = 1'b0;
      bus.data_sent   = 1'b0;
      bus.line_done   = 1'b0;
      bus.arc_done    = 1'b0;
      test_reset();
      test_triangle();
      test_polygon_stall();
      test_circle();
      test_errors();
      test_line_pixels();
      test_reset_mid_shape();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
